// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data cache controller.
// Holds the FSM state encoding, line geometry and the byte-merge function.
package dcache_pkg;

    localparam int LINE_BYTES = 8;
    localparam int OFFSET_W   = 3;

    typedef enum logic [2:0] {
        ST_DRAIN  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MISS   = 3'd3,
        ST_FILL   = 3'd4,
        ST_WRITE  = 3'd5
    } dc_state_t;

    function automatic logic [63:0] merge_be(
        input logic [63:0] line,
        input logic [63:0] wdata,
        input logic [7:0]  be
    );
        logic [63:0] r;
        r = line;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache, one line per index.
// Ports: clk, clr (sync valid clear), rd_* (comb read), wr_* (single write).
module dcache_array import dcache_pkg::*; #(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - OFFSET_W - IDX_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [63:0]      data [LINES];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, write-allocate data cache controller.
// Ports: cpu_* request/response, daddr/dmiss/dfill/mem_data fill, we/addr_in/data_in write-through.
module dcache_ctrl import dcache_pkg::*; #(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int DRAIN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic [7:0]  cpu_be,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [63:0] cpu_rdata,
    output logic [31:0] daddr,
    output logic        dmiss,
    input  logic        dfill,
    input  logic [63:0] mem_data,
    output logic        we,
    output logic [31:0] addr_in,
    output logic [63:0] data_in
);

    localparam int TAG_W = 32 - OFFSET_W - IDX_W;
    localparam int CNT_W = $clog2(DRAIN + 1);

    dc_state_t        state;
    logic [CNT_W-1:0] drain_cnt;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [63:0]      wdata_q;
    logic [7:0]       be_q;
    logic [63:0]      line_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      aligned;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [63:0]      rd_data;
    logic             hit;
    logic [63:0]      merged;
    logic             wr_en;
    logic [63:0]      wr_data;
    logic             act;

    assign idx     = addr_q[OFFSET_W +: IDX_W];
    assign tag_q   = addr_q[31 -: TAG_W];
    assign aligned = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign hit     = rd_valid && (rd_tag == tag_q);
    assign merged  = merge_be((state == ST_FILL) ? line_q : rd_data,
                              wdata_q, be_q);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = merged;
        case (state)
            ST_LOOKUP: wr_en = hit && we_q;
            ST_MISS: begin
                wr_en   = dfill;
                wr_data = mem_data;
            end
            ST_FILL:   wr_en = we_q;
            default:   wr_en = 1'b0;
        endcase
        if (reset) wr_en = 1'b0;
    end

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .clr      (reset),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag_q),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_DRAIN: begin
                    if (drain_cnt == CNT_W'(DRAIN - 1)) state <= ST_IDLE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                ST_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        be_q    <= cpu_be;
                        state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!hit) begin
                        state <= ST_MISS;
                    end else if (we_q) begin
                        line_q <= merged;
                        state  <= ST_WRITE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MISS: begin
                    if (dfill) begin
                        line_q <= mem_data;
                        state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (we_q) begin
                        line_q <= merged;
                        state  <= ST_WRITE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_DRAIN;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, whatever state we were in.
    assign act       = !reset;
    assign cpu_ready = act && (state == ST_IDLE);
    assign dmiss     = act && (state == ST_MISS);
    assign we        = act && (state == ST_WRITE);
    assign daddr     = dmiss ? aligned : 32'h0;
    assign addr_in   = we ? aligned : 32'h0;
    assign data_in   = we ? line_q : 64'h0;

    always_comb begin
        cpu_done  = 1'b0;
        cpu_rdata = 64'h0;
        if (act) begin
            case (state)
                ST_LOOKUP: if (hit && !we_q) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = rd_data;
                end
                ST_FILL: if (!we_q) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = line_q;
                end
                ST_WRITE: cpu_done = 1'b1;
                default:  cpu_done = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector table plus reset-during-miss sequence.
// Models the memory side (fill responder, write-through target).
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [7:0]  cpu_be;
    logic        cpu_ready;
    logic        cpu_done;
    logic [63:0] cpu_rdata;
    logic [31:0] daddr;
    logic        dmiss;
    logic        dfill;
    logic [63:0] mem_data;
    logic        we;
    logic [31:0] addr_in;
    logic [63:0] data_in;

    localparam logic [63:0] JUNK = 64'hDEADBEEFCAFEF00D;

    dcache_ctrl #(.LINES(64), .DRAIN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .daddr     (daddr),
        .dmiss     (dmiss),
        .dfill     (dfill),
        .mem_data  (mem_data),
        .we        (we),
        .addr_in   (addr_in),
        .data_in   (data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        exp_miss;
        logic [63:0] exp_data;
        logic [31:0] exp_waddr;
    } vec_t;

    vec_t        vecs [11];
    logic [63:0] mem [logic [31:0]];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 64'h0;
        cpu_be    = 8'h0;
        dfill     = 1'b0;
        mem_data  = JUNK;
    endtask

    task automatic issue(input vec_t v, input string nm, output logic ok);
        int n;
        n = 0;
        while (!cpu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = cpu_ready;
        if (!ok) begin
            chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        cpu_req   = 1'b1;
        cpu_we    = v.st;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_be    = v.be;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'hFFFF_FFF8;
        cpu_wdata = JUNK;
        cpu_be    = 8'hFF;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        string       nm;
        logic        ok;
        int          cyc, fill_cyc, miss_cnt, we_cnt, exp_lat;
        logic        saw_miss, done, rearm;
        logic [63:0] rd, wd;
        logic [31:0] wa;
        nm = $sformatf("v%0d", id);
        issue(v, nm, ok);
        if (!ok) return;
        cyc = 1; fill_cyc = -1; miss_cnt = 0; we_cnt = 0;
        saw_miss = 0; done = 0; rearm = 0;
        rd = '0; wd = '0; wa = '0;
        while (!done && cyc < 50) begin
            dfill    = 1'b0;
            mem_data = JUNK;
            if (dmiss) begin
                saw_miss = 1;
                miss_cnt++;
                if (fill_cyc >= 0) rearm = 1;
                if (miss_cnt == 1) begin
                    chk({nm, "_daddr"}, 64'(daddr),
                        64'({v.addr[31:3], 3'b000}));
                end
                if (miss_cnt == 2) begin
                    dfill    = 1'b1;
                    mem_data = mem.exists(daddr) ? mem[daddr] : 64'h0;
                    fill_cyc = cyc;
                end
            end
            if (we) begin
                we_cnt++;
                wa = addr_in;
                wd = data_in;
                mem[addr_in] = data_in;
            end
            if (cpu_done) begin
                done = 1;
                rd   = cpu_rdata;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        dfill    = 1'b0;
        mem_data = JUNK;
        if (!done) begin
            chk({nm, "_done_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({nm, "_miss"}, 64'(saw_miss), 64'(v.exp_miss));
        chk({nm, "_no_rearm"}, 64'(rearm), 64'd0);
        exp_lat = (v.exp_miss ? fill_cyc + 1 : 1) + (v.st ? 1 : 0);
        chk({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
        if (v.st) begin
            chk({nm, "_we_cnt"}, 64'(we_cnt), 64'd1);
            chk({nm, "_addr_in"}, 64'(wa), 64'(v.exp_waddr));
            chk({nm, "_data_in"}, wd, v.exp_data);
        end else begin
            chk({nm, "_we_cnt"}, 64'(we_cnt), 64'd0);
            chk({nm, "_rdata"}, rd, v.exp_data);
        end
        @(negedge clk);
        chk({nm, "_pulse_ready"}, 64'({cpu_done, cpu_ready}), 64'b01);
    endtask

    task automatic drain_count(input string nm, input logic stray);
        int   n;
        logic any_done;
        n = 0;
        any_done = 0;
        while (!cpu_ready && n < 20) begin
            if (cpu_done) any_done = 1;
            dfill    = stray && (n == 2);
            mem_data = dfill ? 64'hBADBADBADBADBAD0 : JUNK;
            @(negedge clk);
            n++;
        end
        dfill    = 1'b0;
        mem_data = JUNK;
        chk({nm, "_drain_cycles"}, 64'(n), 64'd4);
        chk({nm, "_no_done"}, 64'(any_done), 64'd0);
    endtask

    function automatic logic quiet();
        return |{cpu_ready, cpu_done, dmiss, we,
                 cpu_rdata, daddr, addr_in, data_in};
    endfunction

    initial begin
        vec_t v;
        int   n;
        logic ok;

        vecs[0]  = '{1'b0, 32'h40,  64'h0, 8'h00, 1'b1,
                     64'h1122334455667788, 32'h0};
        vecs[1]  = '{1'b0, 32'h40,  64'h0, 8'h00, 1'b0,
                     64'h1122334455667788, 32'h0};
        vecs[2]  = '{1'b1, 32'h44,  64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0,
                     64'h11223344BBBBBBBB, 32'h40};
        vecs[3]  = '{1'b0, 32'h40,  64'h0, 8'h00, 1'b0,
                     64'h11223344BBBBBBBB, 32'h0};
        vecs[4]  = '{1'b0, 32'h240, 64'h0, 8'h00, 1'b1,
                     64'h0123456789ABCDEF, 32'h0};
        vecs[5]  = '{1'b0, 32'h40,  64'h0, 8'h00, 1'b1,
                     64'h11223344BBBBBBBB, 32'h0};
        vecs[6]  = '{1'b1, 32'h200, 64'hCCCCCCCC00000000, 8'hF0, 1'b1,
                     64'hCCCCCCCC00000000, 32'h200};
        vecs[7]  = '{1'b0, 32'h200, 64'h0, 8'h00, 1'b0,
                     64'hCCCCCCCC00000000, 32'h0};
        vecs[8]  = '{1'b1, 32'h20C, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1,
                     64'h5555555555555555, 32'h208};
        vecs[9]  = '{1'b0, 32'h300, 64'h0, 8'h00, 1'b1,
                     64'h3030303030303030, 32'h0};
        vecs[10] = '{1'b0, 32'h200, 64'h0, 8'h00, 1'b1,
                     64'hCCCCCCCC00000000, 32'h0};

        mem[32'h40]  = 64'h1122334455667788;
        mem[32'h240] = 64'h0123456789ABCDEF;
        mem[32'h200] = 64'h0;
        mem[32'h208] = 64'h5555555555555555;
        mem[32'h300] = 64'h3030303030303030;

        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outputs", 64'(quiet()), 64'd0);
        @(negedge clk);
        chk("rst_outputs2", 64'(quiet()), 64'd0);
        reset = 1'b0;
        drain_count("init", 1'b0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        v = '{1'b0, 32'h300, 64'h0, 8'h00, 1'b1, 64'h0, 32'h0};
        issue(v, "rstmiss", ok);
        if (ok) begin
            n = 0;
            while (!dmiss && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("rstmiss_dmiss_seen", 64'(dmiss), 64'd1);
            reset = 1'b1;
            @(negedge clk);
            chk("rstmiss_dmiss_drop", 64'(dmiss), 64'd0);
            chk("rstmiss_quiet", 64'(quiet()), 64'd0);
            reset = 1'b0;
            drain_count("rstmiss", 1'b1);
        end

        for (int i = 9; i < 11; i++) run_vec(vecs[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, write-allocate data cache controller directly upstream of the shared memory block.
- CPU side: one outstanding load/store at a time, with 64-bit doublewords and byte enables.
- Memory side: drives the data-miss request (daddr/dmiss), consumes the 64-bit line returned with dfill, and issues full-doubleword write-through (we/addr_in/data_in).
- Line size is 8 bytes, matching the memory's fill width.

Parameters:
- LINES, 64, number of cache lines; power of two, at least 2.
- IDX_W, $clog2(LINES), index width, derived.
- DRAIN, 4, cycles `cpu_ready` is held low after reset so an in-flight memory fill pipeline empties.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [2:0] ignored (doubleword aligned).
- cpu_wdata  in  64  store data.
- cpu_be  in  8  store byte enables; bit i covers bits [8i+7:8i].
- cpu_ready  out  1  controller can accept a request this cycle.
- cpu_done  out  1  one-cycle pulse: request complete.
- cpu_rdata  out  64  load data, valid while `cpu_done`=1 for a load.
- daddr  out  32  miss address: {tag, index, 3'b000}.
- dmiss  out  1  data-miss request to memory.
- dfill  in  1  memory fill strobe, one cycle.
- mem_data  in  64  memory line data, sampled only when `dfill`=1.
- we  out  1  write-through strobe, one cycle.
- addr_in  out  32  write-through address, doubleword aligned.
- data_in  out  64  write-through data: the full merged line.

Behaviour:
- Storage:
  - per line: valid bit, tag of (32-3-IDX_W) bits, 64-bit data, all in flops.
  - index = addr[3+IDX_W-1:3]; tag = addr[31:3+IDX_W].
- Request latch: a request is accepted when `cpu_req` && `cpu_ready`. The controller latches addr, we, wdata and be at that edge.
- FSM states: DRAIN, IDLE, LOOKUP, MISS, FILL, WRITE.
- DRAIN:
  - entered on reset.
  - drain counter counts DRAIN cycles, then the FSM goes to IDLE.
  - `dfill` is ignored in this state.
- IDLE: `cpu_ready`=1; on accept go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag match.
  - Load hit: `cpu_done`=1 and `cpu_rdata`=line; go to IDLE. Latency is accept + 1 cycle.
  - Store hit: merge bytes where be=1 into the line and update the array. Next go to WRITE.
  - Any miss: go to MISS.
- MISS:
  - `dmiss`=1 and `daddr` = the aligned latched address, both held stable.
  - on the edge where `dfill`=1:
    - write mem_data into line[idx], set valid, write the tag.
    - `dmiss` drops at that same edge, because memory re-arms 1 cycle later and a held `dmiss` would refetch.
    - go to FILL.
- FILL:
  - Load: `cpu_done`=1, `cpu_rdata` = the filled line; go to IDLE.
  - Store: merge into the filled line; go to WRITE.
- WRITE:
  - `we`=1 for exactly one cycle, with `addr_in` = aligned address and `data_in` = the merged line.
  - `cpu_done`=1 in the same cycle; go to IDLE.
  - A store with be=8'h00 still performs the write-through, with line data unchanged.
- `dfill` outside MISS is ignored: no array update and no `cpu_done`.
- `mem_data` is shared with instruction fills; it is qualified only by `dfill`.
- Output values during reset and in DRAIN: cpu_ready=0, cpu_done=0, dmiss=0, we=0, cpu_rdata=0, daddr=0, addr_in=0, data_in=0.
- Reset:
  - all valid bits clear in the reset cycle.
  - tags and data are unreset.
  - reset during MISS drops `dmiss` the next cycle and enters DRAIN.
- Back-to-back: a new request can be accepted in the cycle after `cpu_done`, never in the same cycle.
- `cpu_req` is a don't-care while `cpu_ready`=0; the requester holds the request until it is accepted.

Decomposition:
- Package `dcache_pkg`:
  - state enum `dc_state_t`.
  - LINE_BYTES=8, OFFSET_W=3.
  - function `merge_be(line, wdata, be)` returning the merged 64-bit line.
- One sub-module, `dcache_array`: valid/tag/data storage with a combinational read port, one write port and a synchronous valid clear.
- The FSM, latch and memory interface stay in `dcache_ctrl`.

Test Plan:
1. Reset, then load 0x40 (miss). Memory holds 0x1122334455667788 at 0x40.
   -> dmiss=1 with daddr=0x40 until dfill; cpu_done one cycle after dfill with cpu_rdata=0x1122334455667788; dmiss never re-asserts.
2. Load 0x40 again.
   -> hit: cpu_done at accept+1 with the same data, dmiss stays 0.
3. Store to 0x44 (same line), be=8'h0F, wdata=0xAAAAAAAABBBBBBBB.
   -> cpu_done at accept+2 (WRITE); we=1 one cycle with addr_in=0x40 and data_in=0x11223344BBBBBBBB.
   -> a following load of 0x40 returns that value without dmiss.
4. Conflict: load 0x40+8*LINES (same index, different tag).
   -> miss; the fill replaces the line; a later load of 0x40 misses again.
5. Store miss at 0x200, be=8'hF0, wdata=0xCCCCCCCC00000000, memory holds 0.
   -> dmiss, fill, then we with data_in=0xCCCCCCCC00000000 and addr_in=0x200, cpu_done in the same cycle.
6. Reset asserted while in MISS, with a stray dfill 2 cycles later.
   -> dmiss=0 after reset; cpu_ready=0 for DRAIN cycles; the stray dfill causes no cpu_done and sets no valid bit; the first load after DRAIN misses.
